// File: rtl/uart_tx_periph.sv
// uart_tx_periph: bus-mapped 8N1 UART transmitter.
//
// Register map (only wraddr[3:2] is decoded, so every address aliases):
//   0x0 CTRL   [0] tx_en (R/W)
//   0x4 STATUS [0] busy (RO), [1] done (sticky), [2] overrun (sticky).
//              Any write clears done and overrun.
//   0x8 DIV    [15:0] clocks per bit. A written 0 is stored as 1.
//   0xC TXDATA [7:0] last accepted byte. A write starts a frame.
//
// Bus handshake: there is no ready/valid pair. A write takes effect on the
// rising edge where we=1. rdata is a pure combinational function of wraddr
// and has no side effects.
//
// Timing: an accepted TXDATA write at edge N puts the line low from cycle
// N+1. Start, eight data bits (LSB first) and stop each last exactly DIV
// cycles, where DIV is the value latched at acceptance. The frame is
// therefore 10*DIV cycles long. The edge that leaves STOP also returns the
// FSM to IDLE and sets done.
module uart_tx_periph #(
  parameter logic [31:0] DEFAULT_DIV = 32'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wraddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_TXDATA = 2'd3;

  // Architectural registers
  logic        r_tx_en;
  logic        r_done;
  logic        r_overrun;
  logic [15:0] r_div;
  logic [7:0]  r_txdata;

  // Frame engine registers
  state_t      r_state;
  logic [15:0] r_div_lat;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic        r_tx;

  // Next-state signals
  state_t      w_state_next;
  logic [15:0] w_baud_next;
  logic [2:0]  w_bit_next;
  logic        w_tx_next;
  logic        w_done_set;

  // Decode signals
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_wr_div;
  logic        w_wr_txdata;
  logic        w_busy;
  logic        w_accept;
  logic        w_overrun_set;
  logic        w_baud_last;
  logic [15:0] w_div_wdata;

  // Bits of the bus that carry no meaning for this block.
  logic w_unused;
  assign w_unused = &{1'b0, wraddr[31:4], wraddr[1:0], wdata[31:16]};

  assign w_wr_ctrl   = we && (wraddr[3:2] == A_CTRL);
  assign w_wr_status = we && (wraddr[3:2] == A_STATUS);
  assign w_wr_div    = we && (wraddr[3:2] == A_DIV);
  assign w_wr_txdata = we && (wraddr[3:2] == A_TXDATA);

  assign w_busy = (r_state != S_IDLE);

  // A TXDATA write is only meaningful while enabled. When enabled it either
  // starts a frame (idle) or is dropped and flagged (busy, including the
  // final STOP cycle).
  assign w_accept      = w_wr_txdata && r_tx_en && !w_busy;
  assign w_overrun_set = w_wr_txdata && r_tx_en &&  w_busy;

  // Zero would stall the baud counter, so it is promoted to one.
  assign w_div_wdata = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];

  assign w_baud_last = (r_baud == (r_div_lat - 16'd1));

  // Register file: CTRL, DIV, TXDATA and the sticky STATUS flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_en   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_div     <= DEFAULT_DIV[15:0];
      r_txdata  <= 8'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_tx_en <= wdata[0];
      end
      if (w_wr_div) begin
        r_div <= w_div_wdata;
      end
      if (w_accept) begin
        r_txdata <= wdata[7:0];
      end
      // Clear first, set afterwards: a completion coinciding with a STATUS
      // write leaves done=1.
      if (w_wr_status) begin
        r_done    <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_done_set) begin
        r_done <= 1'b1;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Latch the divider at frame start so mid-frame DIV writes wait a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_lat <= DEFAULT_DIV[15:0];
    end else if (w_accept) begin
      r_div_lat <= r_div;
    end
  end

  // FSM state, baud counter, bit index and the registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_tx    <= w_tx_next;
    end
  end

  // Next-state logic. The line level is derived from the next state so that
  // the registered tx changes on the same edge as the state does.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_done_set   = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_START;
          w_baud_next  = 16'd0;
          w_bit_next   = 3'd0;
        end
      end

      S_START: begin
        if (w_baud_last) begin
          w_state_next = S_DATA;
          w_baud_next  = 16'd0;
          w_bit_next   = 3'd0;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = 16'd0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_bit_next   = 3'd0;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      S_STOP: begin
        if (w_baud_last) begin
          w_state_next = S_IDLE;
          w_baud_next  = 16'd0;
          w_done_set   = 1'b1;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = 16'd0;
        w_bit_next   = 3'd0;
      end
    endcase

    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = r_txdata[w_bit_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  // Read mux; purely combinational and free of side effects.
  always_comb begin
    rdata = 32'd0;
    case (wraddr[3:2])
      A_CTRL:   rdata = {31'd0, r_tx_en};
      A_STATUS: rdata = {29'd0, r_overrun, r_done, w_busy};
      A_DIV:    rdata = {16'd0, r_div};
      A_TXDATA: rdata = {24'd0, r_txdata};
      default:  rdata = 32'd0;
    endcase
  end

  assign tx        = r_tx;
  assign dbg_state = r_state;

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 32'd434, the reset value of the DIV register (clocks per bit).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port we  input  1  write strobe from the bus interconnect slave port.
REQ-005 SHALL have port wraddr  input  32  byte address; only bits [3:2] are decoded.
REQ-006 SHALL have port wdata  input  32  write data.
REQ-007 SHALL have port rdata  output  32  read data, combinational from wraddr.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high.

Function
REQ-009 SHALL decode four registers: 0x0 CTRL, 0x4 STATUS, 0x8 DIV, 0xC TXDATA.
REQ-010 SHALL implement CTRL[0] tx_en (R/W), with bits [31:1] reading 0.
REQ-011 SHALL implement STATUS[0] busy (RO), [1] done (sticky), [2] overrun (sticky), with [31:3] reading 0.
REQ-012 SHALL clear both done and overrun on any write to STATUS, regardless of wdata.
REQ-013 SHALL hold DIV[15:0] as clocks per bit and store a written value of 0 as 1; bits [31:16] read 0 and are ignored on write.
REQ-014 SHALL return the last accepted byte on reads of TXDATA in bits [7:0].
REQ-015 SHALL accept a TXDATA write only when busy=0 and tx_en=1: latch wdata[7:0] and DIV, set busy, enter START.
REQ-016 SHALL drop a TXDATA write made while busy=1, set overrun, and leave the frame in flight unchanged.
REQ-017 SHALL ignore a TXDATA write made while tx_en=0 and set no flag.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP, with each state/bit lasting exactly latched-DIV clocks via a baud counter running 0..DIV-1.
REQ-019 SHALL drive tx=0 in START.
REQ-020 SHALL shift the byte out LSB first in DATA, with the bit index running 0..7 before moving to STOP.
REQ-021 SHALL drive tx=1 in STOP and IDLE.
REQ-022 SHALL, on the last STOP cycle, return to IDLE, clear busy, and set done on the following edge.
REQ-023 SHALL drive tx low from cycle N+1 when an accepted TXDATA write occurs at cycle N; a full frame is 10*DIV cycles.
REQ-024 SHALL reject a TXDATA write in the final STOP cycle (busy still 1) as an overrun.
REQ-025 SHALL take DIV changes made mid-frame only at the next frame start.
REQ-026 SHALL complete the current frame if tx_en is cleared mid-frame.
REQ-027 SHALL clear done and set it again in the same cycle when a STATUS write and frame completion coincide, leaving done=1 (set wins).
REQ-028 SHALL return 0 on reads of unmapped addresses; such writes have no effect.
REQ-029 SHALL cause no side effect on rdata reads.

Reset
REQ-030 SHALL apply on reset: CTRL=0, STATUS=0, DIV=DEFAULT_DIV, TXDATA=0, FSM=IDLE, baud counter=0, bit index=0, tx=1.
REQ-031 SHALL abort a frame in flight when reset is asserted, with tx=1 on the next edge and no done flag.

Verification
REQ-032 SHALL pass: DIV=4, tx_en=1, TXDATA=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; busy=1 for 40 cycles; then done=1.
REQ-033 SHALL pass: second TXDATA write 0x3C at cycle 10 of the frame above -> overrun=1 and the frame still transmits 0xA5 unchanged.
REQ-034 SHALL pass: tx_en=0 with TXDATA=0x55 -> tx stays 1, busy=0, overrun=0.
REQ-035 SHALL pass: DIV write 0 then read -> 1; DIV=1 with TXDATA=0xFF -> frame is 0 then nine 1s, 10 cycles.
REQ-036 SHALL pass: rst asserted at cycle 15 of a DIV=4 frame -> tx=1, busy=0, DIV=434 on the next cycle.
REQ-037 SHALL pass: STATUS write in the same cycle as frame completion -> done=1, overrun=0 afterwards.
